sc_lane_scheduler: RTL and testbench

//  Schedules obstacle-lane scrolling for the frogger playfield. Each lane advances at a

---
 rtl/sc_lane_scheduler_pkg.sv | 30 +++
 rtl/sc_lane_scheduler_lane_timer.sv | 55 +++++
 rtl/sc_lane_scheduler.sv | 142 ++++++++++++++
 tb/tb_sc_lane_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_lane_scheduler_pkg.sv
// Shared definitions for the frogger lane scheduler: state encoding, lane period table
// and default timing constants.
package sc_lane_scheduler_pkg;

    localparam int LEVEL_W       = 2;
    localparam int PER_W         = 3;
    localparam int NUM_LANES_DEF = 8;
    localparam int BASE_DIV_DEF  = 2500000;
    localparam int DIV_W_DEF     = 22;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CHECK = 3'd3,
        ST_HOLD  = 3'd4
    } sched_state_t;

    // Base ticks between shifts of one lane; higher levels speed lanes up, never below 1.
    function automatic logic [PER_W-1:0] lane_period(input int lane,
                                                      input logic [LEVEL_W-1:0] level);
        int p;
        p = (lane % 4) + 2 - int'(level);
        if (p < 1) begin
            p = 1;
        end
        return p[PER_W-1:0];
    endfunction

endpackage

// File: rtl/sc_lane_scheduler_lane_timer.sv
// One obstacle lane: base-tick down-counter with terminal-count reload and a sticky
// pending flag that survives until the scheduler consumes it.
module sc_lane_timer
    import sc_lane_scheduler_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic               SC_STATEMACHINEGAME_CLOCK_50,
    input  logic               SC_STATEMACHINEGAME_RESET_InHigh,
    input  logic [LEVEL_W-1:0] level_i,
    input  logic               load_i,
    input  logic               tick_i,
    input  logic               clr_pend_i,
    output logic               pend_o
);

    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             pend_q, pend_d;
    logic             due;

    always_comb begin
        cnt_d  = cnt_q;
        per_d  = per_q;
        pend_d = pend_q;
        due    = 1'b0;
        if (load_i) begin
            per_d  = lane_period(LANE, level_i);
            cnt_d  = per_d;
            pend_d = 1'b0;
        end else begin
            if (tick_i) begin
                due   = (cnt_q == PER_W'(1));
                cnt_d = due ? per_q : cnt_q - PER_W'(1);
            end
            // A lane falling due on the same edge the flag is consumed is kept.
            pend_d = (pend_q & ~clr_pend_i) | due;
        end
    end

    always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or posedge SC_STATEMACHINEGAME_RESET_InHigh) begin
        if (SC_STATEMACHINEGAME_RESET_InHigh) begin
            cnt_q  <= '0;
            per_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/sc_lane_scheduler.sv
// Lane scroll scheduler: prescaler, batching of due lanes into one shift strobe and the
// collision-check handshake with the matrix comparator.
//
//  state | meaning
//  IDLE  | after reset, waiting for the first start strobe
//  RUN   | prescaler running, waiting for any lane to fall due
//  SHIFT | single-cycle shift strobe of all pending lanes
//  CHECK | collision check requested, waiting for the comparator ack
//  HOLD  | game over/won, lanes frozen until restarted
module sc_lane_scheduler
    import sc_lane_scheduler_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int BASE_DIV  = BASE_DIV_DEF,
    parameter int DIV_W     = DIV_W_DEF
) (
    input  logic                 SC_STATEMACHINEGAME_CLOCK_50,
    input  logic                 SC_STATEMACHINEGAME_RESET_InHigh,
    input  logic                 SC_LANESCHED_startGame_InLow,
    input  logic                 SC_LANESCHED_LoadGame_InLow,
    input  logic                 SC_LANESCHED_Freeze_InLow,
    input  logic [LEVEL_W-1:0]   SC_LANESCHED_Level_InBUS,
    input  logic                 SC_LANESCHED_CheckAck_InHigh,
    output logic [NUM_LANES-1:0] SC_LANESCHED_Shift_OutBUS,
    output logic [NUM_LANES-1:0] SC_LANESCHED_Dir_OutBUS,
    output logic                 SC_LANESCHED_CheckReq_OutHigh,
    output logic                 SC_LANESCHED_Running_OutHigh
);

    sched_state_t         state_q, state_d;
    logic [DIV_W-1:0]     pre_q, pre_d;
    logic [NUM_LANES-1:0] shift_q, shift_d;
    logic                 req_q, req_d;
    logic                 run_q, run_d;

    logic                 reload;
    logic                 advance;
    logic                 tick;
    logic                 clr_pend;
    logic [NUM_LANES-1:0] pend;

    always_comb begin
        state_d  = state_q;
        reload   = 1'b0;
        advance  = 1'b0;
        clr_pend = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!SC_LANESCHED_startGame_InLow) begin
                    reload  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (SC_LANESCHED_Freeze_InLow && !SC_LANESCHED_startGame_InLow) begin
                    reload  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (!SC_LANESCHED_Freeze_InLow) begin
                    clr_pend = 1'b1;
                    state_d  = ST_HOLD;
                end else if (!SC_LANESCHED_startGame_InLow || !SC_LANESCHED_LoadGame_InLow) begin
                    // Abandons any check in flight; a later ack lands outside CHECK.
                    reload  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    advance = 1'b1;
                    case (state_q)
                        ST_RUN: begin
                            if (|pend) begin
                                clr_pend = 1'b1;
                                state_d  = ST_SHIFT;
                            end
                        end
                        ST_SHIFT: state_d = ST_CHECK;
                        ST_CHECK: begin
                            if (SC_LANESCHED_CheckAck_InHigh) begin
                                state_d = ST_RUN;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        tick  = advance && (pre_q == DIV_W'(BASE_DIV - 1));
        pre_d = pre_q;
        if (reload) begin
            pre_d = '0;
        end else if (advance) begin
            pre_d = tick ? '0 : pre_q + DIV_W'(1);
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        shift_d = (state_d == ST_SHIFT) ? pend : '0;
        req_d   = (state_d == ST_CHECK);
        run_d   = (state_d == ST_RUN) || (state_d == ST_SHIFT) || (state_d == ST_CHECK);
    end

    always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or posedge SC_STATEMACHINEGAME_RESET_InHigh) begin
        if (SC_STATEMACHINEGAME_RESET_InHigh) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            shift_q <= '0;
            req_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            shift_q <= shift_d;
            req_q   <= req_d;
            run_q   <= run_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sc_lane_timer #(
            .LANE(g)
        ) u_timer (
            .SC_STATEMACHINEGAME_CLOCK_50    (SC_STATEMACHINEGAME_CLOCK_50),
            .SC_STATEMACHINEGAME_RESET_InHigh(SC_STATEMACHINEGAME_RESET_InHigh),
            .level_i                         (SC_LANESCHED_Level_InBUS),
            .load_i                          (reload),
            .tick_i                          (tick),
            .clr_pend_i                      (clr_pend),
            .pend_o                          (pend[g])
        );
        assign SC_LANESCHED_Dir_OutBUS[g] = ((g % 2) == 1);
    end

    assign SC_LANESCHED_Shift_OutBUS     = shift_q;
    assign SC_LANESCHED_CheckReq_OutHigh = req_q;
    assign SC_LANESCHED_Running_OutHigh  = run_q;

endmodule

// File: tb/tb_sc_lane_scheduler.sv
// Directed bench for sc_lane_scheduler with a tick-count based reference model and
// hand-computed strobe timings.
module tb_sc_lane_scheduler;

    localparam int BD = 4;
    localparam int NL = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_SHIFT = 2, M_CHECK = 3, M_HOLD = 4;

    logic          clk;
    logic          rst;
    logic          st_n, ld_n, fz_n;
    logic [1:0]    lvl;
    logic          ack;
    logic [NL-1:0] sh, dir;
    logic          req, run;

    int checks = 0;
    int errors = 0;
    bit auto_ack = 1'b1;
    int req_age = 0;

    sc_lane_scheduler #(.NUM_LANES(NL), .BASE_DIV(BD), .DIV_W(22)) dut (
        .SC_STATEMACHINEGAME_CLOCK_50    (clk),
        .SC_STATEMACHINEGAME_RESET_InHigh(rst),
        .SC_LANESCHED_startGame_InLow    (st_n),
        .SC_LANESCHED_LoadGame_InLow     (ld_n),
        .SC_LANESCHED_Freeze_InLow       (fz_n),
        .SC_LANESCHED_Level_InBUS        (lvl),
        .SC_LANESCHED_CheckAck_InHigh    (ack),
        .SC_LANESCHED_Shift_OutBUS       (sh),
        .SC_LANESCHED_Dir_OutBUS         (dir),
        .SC_LANESCHED_CheckReq_OutHigh   (req),
        .SC_LANESCHED_Running_OutHigh    (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int per(input int i, input int l);
        int p;
        p = (i % 4) + 2 - l;
        return (p < 1) ? 1 : p;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: lanes fall due when the tick index is a multiple of their period.
    int          ph = M_IDLE;
    int          m_lvl = 0;
    int          acyc = 0;
    int          k = 0;
    logic [NL-1:0] pend = '0;
    logic [NL-1:0] e_sh = '0;

    task automatic restart(input int l);
        m_lvl = l;
        acyc  = 0;
        k     = 0;
        pend  = '0;
        ph    = M_RUN;
    endtask

    initial begin
        logic          s_rst, s_st, s_ld, s_fz, s_ack;
        int            s_lvl;
        logic [NL-1:0] due;
        forever begin
            @(posedge clk);
            s_rst = rst; s_st = st_n; s_ld = ld_n; s_fz = fz_n; s_ack = ack; s_lvl = int'(lvl);
            e_sh = '0;
            if (s_rst) begin
                ph   = M_IDLE;
                pend = '0;
            end else if (ph == M_IDLE) begin
                if (!s_st) restart(s_lvl);
            end else if (ph == M_HOLD) begin
                if (s_fz && !s_st) restart(s_lvl);
            end else if (!s_fz) begin
                ph   = M_HOLD;
                pend = '0;
            end else if (!s_st || !s_ld) begin
                restart(s_lvl);
            end else begin
                due = '0;
                if (acyc % BD == BD - 1) begin
                    k++;
                    for (int i = 0; i < NL; i++)
                        if (k % per(i, m_lvl) == 0) due[i] = 1'b1;
                end
                acyc++;
                if (ph == M_RUN) begin
                    if (pend != 0) begin
                        e_sh = pend;
                        pend = due;
                        ph   = M_SHIFT;
                    end else begin
                        pend = pend | due;
                    end
                end else if (ph == M_SHIFT) begin
                    pend = pend | due;
                    ph   = M_CHECK;
                end else begin
                    pend = pend | due;
                    if (s_ack) ph = M_RUN;
                end
            end
            #1;
            chk("model_shift", 32'(sh), 32'(e_sh));
            chk("model_req", 32'(req), 32'(ph == M_CHECK));
            chk("model_running", 32'(run), 32'(ph == M_RUN || ph == M_SHIFT || ph == M_CHECK));
        end
    end

    // Comparator stand-in: acks once a request has been seen for two sampling points.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack) begin
                req_age = req ? req_age + 1 : 0;
                ack = req && (req_age >= 2);
            end
        end
    end

    task automatic start_game(input logic [1:0] l);
        @(negedge clk);
        st_n = 1'b0;
        lvl  = l;
        @(negedge clk);
        st_n = 1'b1;
    endtask

    task automatic wait_shift(output logic [NL-1:0] v, output int n);
        v = '0;
        n = 999;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (sh != 0) begin
                v = sh;
                n = i;
                return;
            end
        end
    endtask

    task automatic wait_lane(input int lane, output int n);
        n = 999;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (sh[lane]) begin
                n = i;
                return;
            end
        end
    endtask

    initial begin
        logic [NL-1:0] v;
        int n, bad;
        rst = 1'b1; st_n = 1'b1; ld_n = 1'b1; fz_n = 1'b1; lvl = 2'd0; ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_shift", 32'(sh), 0);
        chk("reset_req", 32'(req), 0);
        chk("reset_running", 32'(run), 0);
        chk("dir_const", 32'(dir), 32'h0000_00AA);

        // Level 0: lanes 0/4 every two ticks, lane 3 every five ticks.
        start_game(2'd0);
        chk("running_after_start", 32'(run), 1);
        wait_shift(v, n);
        chk("lvl0_first_shift_cycle", 32'(n), 9);
        chk("lvl0_first_shift_val", 32'(v), 32'h11);
        wait_lane(0, n);
        chk("lvl0_lane0_gap", 32'(n), 8);
        wait_lane(3, n);
        wait_lane(3, n);
        chk("lvl0_lane3_gap", 32'(n), 20);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sh[0] != sh[4]) bad++;
        end
        chk("lanes0_4_together", 32'(bad), 0);

        // Reset in the middle of a run.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrun_reset_shift", 32'(sh), 0);
        chk("midrun_reset_req", 32'(req), 0);
        chk("midrun_reset_running", 32'(run), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sh != 0 || run) bad++;
        end
        chk("idle_quiet", 32'(bad), 0);

        // Level 3: six lanes every tick, lanes 3 and 7 every second tick.
        start_game(2'd3);
        wait_shift(v, n);
        chk("lvl3_first_shift_cycle", 32'(n), 5);
        chk("lvl3_first_shift_val", 32'(v), 32'h77);
        wait_shift(v, n);
        chk("lvl3_second_shift_cycle", 32'(n), 4);
        chk("lvl3_second_shift_val", 32'(v), 32'hFF);

        // Stalled comparator: due lanes accumulate into one strobe.
        start_game(2'd0);
        wait_shift(v, n);
        chk("stall_first_shift_val", 32'(v), 32'h11);
        auto_ack = 1'b0;
        ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sh != 0) bad++;
        end
        chk("stall_no_shift", 32'(bad), 0);
        chk("stall_req_held", 32'(req), 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        auto_ack = 1'b1;
        wait_shift(v, n);
        chk("stall_or_shift_val", 32'(v), 32'hFF);
        wait_shift(v, n);
        chk("stall_next_shift_val", 32'(v), 32'h33);

        // Level change while a check is in flight.
        start_game(2'd0);
        auto_ack = 1'b0;
        ack = 1'b0;
        n = 0;
        while (!req && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("load_saw_req", 32'(req), 1);
        ld_n = 1'b0;
        lvl  = 2'd2;
        @(negedge clk);
        ld_n = 1'b1;
        chk("load_req_dropped", 32'(req), 0);
        chk("load_running", 32'(run), 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        auto_ack = 1'b1;
        wait_lane(3, n);
        wait_lane(3, n);
        chk("lvl2_lane3_gap", 32'(n), 12);
        wait_lane(0, n);
        wait_lane(0, n);
        chk("lvl2_lane0_gap", 32'(n), 4);

        // Freeze while lanes 0/4 are pending.
        start_game(2'd0);
        repeat (8) @(negedge clk);
        fz_n = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) ld_n = 1'b0;
            if (i == 3) ld_n = 1'b1;
            if (i == 5) fz_n = 1'b1;
            if (sh != 0 || run || req) bad++;
        end
        chk("hold_quiet", 32'(bad), 0);
        start_game(2'd0);
        wait_shift(v, n);
        chk("resume_shift_cycle", 32'(n), 9);
        chk("resume_shift_val", 32'(v), 32'h11);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
